// File: rtl/bank_htu_pkg.sv
// Shared types and tree-PLRU helpers for the HTU bank replacement logic.
// Helpers work on maximum-width trees; callers pass the real tree depth.
package bank_htu_pkg;

  localparam int MAX_WAYS = 32;
  localparam int MAX_LVL  = 5;

  typedef logic [MAX_WAYS-2:0] plru_tree_t;
  typedef logic [MAX_WAYS-1:0] way_mask_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } htu_fsm_e;

  // Point every node on the accessed way's path away from it; lowest set bit wins.
  function automatic plru_tree_t plru_path_update(plru_tree_t state, way_mask_t way,
                                                  int unsigned lvl);
    plru_tree_t         nxt;
    logic [MAX_LVL-1:0] idx;
    logic               found;
    logic               dir;
    int                 node;
    nxt   = state;
    idx   = '0;
    found = 1'b0;
    dir   = 1'b0;
    node  = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (way[i]) begin
        idx   = MAX_LVL'(i);
        found = 1'b1;
      end
    end
    if (found) begin
      for (int l = 0; l < MAX_LVL; l++) begin
        if (l < int'(lvl)) begin
          dir       = idx[int'(lvl) - 1 - l];
          nxt[node] = ~dir;
          node      = 2 * node + 1 + int'(dir);
        end
      end
    end
    return nxt;
  endfunction

  function automatic logic subtree_locked(way_mask_t lock, int lo, int n);
    logic all_locked;
    all_locked = 1'b1;
    for (int i = 0; i < MAX_WAYS; i++) begin
      if (i >= lo && i < lo + n && !lock[i]) all_locked = 1'b0;
    end
    return all_locked;
  endfunction

  // Follow the tree bits, steering into the sibling when a subtree is fully locked.
  function automatic way_mask_t plru_victim(plru_tree_t state, way_mask_t lock_mask,
                                            int unsigned lvl);
    int        node;
    int        base;
    int        span;
    int        half;
    logic      dir;
    way_mask_t v;
    node = 0;
    base = 0;
    span = 1 << int'(lvl);
    half = 0;
    dir  = 1'b0;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < int'(lvl)) begin
        half = span / 2;
        dir  = state[node];
        if (!dir && subtree_locked(lock_mask, base, half)) dir = 1'b1;
        else if (dir && subtree_locked(lock_mask, base + half, half)) dir = 1'b0;
        if (dir) base = base + half;
        node = 2 * node + 1 + int'(dir);
        span = half;
      end
    end
    v       = '0;
    v[base] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bank_htu_plru_victim_sel.sv
// Combinational victim choice: invalid-and-unlocked ways first, then the PLRU walk.
module bank_htu_plru_victim_sel
  import bank_htu_pkg::*;
#(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0] tree,
  input  logic [WAYS-1:0] invalid,
  input  logic [WAYS-1:0] lock,
  output logic [WAYS-1:0] victim,
  output logic            none
);

  localparam int LVL = $clog2(WAYS);

  logic [WAYS-1:0] cand;
  plru_tree_t      tree_ext;
  way_mask_t       lock_ext;
  way_mask_t       walk;

  assign cand = invalid & ~lock;

  always_comb begin
    tree_ext             = '0;
    tree_ext[WAYS-2:0]   = tree;
    lock_ext             = '0;
    lock_ext[WAYS-1:0]   = lock;
    walk                 = plru_victim(tree_ext, lock_ext, LVL);
  end

  always_comb begin
    victim = '0;
    none   = 1'b0;
    if (|cand) begin
      // isolate the lowest set bit
      victim = cand & (~cand + WAYS'(1));
    end else if (&lock) begin
      none = 1'b1;
    end else begin
      victim = walk[WAYS-1:0];
    end
  end

endmodule

// File: rtl/bank_htu_plru_array.sv
// Per-set tree-PLRU state with an access update port, a registered victim query
// port and a one-set-per-cycle clear sweep.
module bank_htu_plru_array
  import bank_htu_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SETS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    upd_valid_i,
  input  logic [$clog2(SETS)-1:0] upd_set_i,
  input  logic [WAYS-1:0]         upd_way_i,
  input  logic                    vic_req_i,
  input  logic [$clog2(SETS)-1:0] vic_set_i,
  input  logic [WAYS-1:0]         vic_invalid_i,
  input  logic [WAYS-1:0]         vic_lock_i,
  output logic                    vic_valid_o,
  output logic [WAYS-1:0]         vic_way_o,
  output logic                    vic_none_o,
  input  logic                    clr_req_i,
  output logic                    busy_o
);

  localparam int SET_W = $clog2(SETS);
  localparam int LVL   = $clog2(WAYS);

  // Handshake: requests are single-cycle strobes sampled only in IDLE; no
  // back-pressure exists, busy_o marks the cycles in which strobes are dropped.

  htu_fsm_e         fsm_state;
  logic [SET_W-1:0] clr_cnt;
  logic [WAYS-2:0]  tree_q [SETS];

  logic            idle;
  plru_tree_t      upd_ext;
  way_mask_t       upd_way_ext;
  plru_tree_t      upd_next;
  logic [WAYS-1:0] sel_way;
  logic            sel_none;

  assign idle   = (fsm_state == IDLE);
  assign busy_o = (fsm_state == CLEAR);

  always_comb begin
    upd_ext                 = '0;
    upd_ext[WAYS-2:0]       = tree_q[upd_set_i];
    upd_way_ext             = '0;
    upd_way_ext[WAYS-1:0]   = upd_way_i;
    upd_next                = plru_path_update(upd_ext, upd_way_ext, LVL);
  end

  // Reads the pre-update state, so a same-cycle update is not seen by the query.
  bank_htu_plru_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .tree    (tree_q[vic_set_i]),
    .invalid (vic_invalid_i),
    .lock    (vic_lock_i),
    .victim  (sel_way),
    .none    (sel_none)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_state <= IDLE;
      clr_cnt   <= '0;
    end else if (idle) begin
      if (clr_req_i) begin
        fsm_state <= CLEAR;
        clr_cnt   <= '0;
      end
    end else begin
      clr_cnt <= clr_cnt + SET_W'(1);
      if (clr_cnt == SET_W'(SETS - 1)) fsm_state <= IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (idle) begin
      if (upd_valid_i) tree_q[upd_set_i] <= upd_next[WAYS-2:0];
    end else begin
      tree_q[clr_cnt] <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vic_valid_o <= 1'b0;
      vic_way_o   <= '0;
      vic_none_o  <= 1'b0;
    end else begin
      vic_valid_o <= idle && vic_req_i;
      if (idle && vic_req_i) begin
        vic_way_o  <= sel_way;
        vic_none_o <= sel_none;
      end
    end
  end

endmodule
